alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties); default is round-robin.
module alu_arbiter #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req0_ctrl,
  input  logic [3:0]  req1_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  input  logic        rsp_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] OP_MULT  = 4'b0101;
  localparam logic [3:0] MUL_LAST = 4'(MUL_LATENCY - 1);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]  ctrl_q, ctrl_d, cnt_q, cnt_d;
  logic        id_q, id_d;
  logic        gnt1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt1 = req1_valid & ~req0_valid;
`else
  // last_q names the most recently served requester; reset to 1 so req0 wins the first tie
  logic last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           last_q <= 1'b1;
    else if (state_q == RESP && rsp_ready) last_q <= id_q;
  end

  assign gnt1 = req1_valid & (~req0_valid | ~last_q);
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = '0;
    case (state_q)
      IDLE: begin
        if (req0_valid | req1_valid) begin
          req0_ready = ~gnt1;
          req1_ready = gnt1;
          a_d        = gnt1 ? req1_a : req0_a;
          b_d        = gnt1 ? req1_b : req0_b;
          ctrl_d     = gnt1 ? req1_ctrl : req0_ctrl;
          id_d       = gnt1;
          cnt_d      = '0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        alu_a    = a_q;
        alu_b    = b_q;
        alu_ctrl = ctrl_q;
        // everything except MULT (including unknown opcodes) finishes in one cycle
        if (ctrl_q != OP_MULT || cnt_q == MUL_LAST) begin
          res_d   = alu_result;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter: a transaction/timing model predicts handshakes,
// ALU drive, response timing and contents every cycle.
module tb_alu_arbiter;
  localparam int L = 3;
  localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_AND = 4'b0011,
                         OP_OR = 4'b0100, OP_MUL = 4'b0101, OP_PASS = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]  alu_ctrl;
  logic        rsp_valid, rsp_id, rsp_ready, busy;

  alu_arbiter #(.MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_MUL:  return a * b;
      OP_PASS: return a;
      default: return 32'd0;
    endcase
  endfunction

  // the shared ALU itself lives in the environment
  always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // model: an op accepted in cycle c executes for E cycles, then waits in RESP for rsp_ready
  bit          chk_en = 1'b0;
  bit          m_busy = 1'b0, m_last = 1'b1, m_id, g1, anyv;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  int          m_acc, cyc = 0, e;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      if (chk_en) begin
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
      end
    end else if (chk_en) begin
      e = (m_op == OP_MUL) ? L : 1;
      if (!m_busy) begin
        anyv = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
        g1 = req1_valid && !req0_valid;
`else
        g1 = req1_valid && (!req0_valid || m_last == 1'b0);
`endif
        chk("idle_busy", busy, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_alu_ctrl", alu_ctrl, 0);
        chk("idle_alu_a", alu_a, 0);
        chk("idle_alu_b", alu_b, 0);
        chk("req0_ready", req0_ready, anyv && !g1);
        chk("req1_ready", req1_ready, g1);
        if (anyv) begin
          m_busy = 1'b1;
          m_acc  = cyc;
          m_id   = g1;
          m_op   = g1 ? req1_ctrl : req0_ctrl;
          m_a    = g1 ? req1_a : req0_a;
          m_b    = g1 ? req1_b : req0_b;
        end
      end else if (cyc <= m_acc + e) begin
        chk("exec_busy", busy, 1);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_ready", {req1_ready, req0_ready}, 0);
        chk("exec_alu_ctrl", alu_ctrl, m_op);
        chk("exec_alu_a", alu_a, m_a);
        chk("exec_alu_b", alu_b, m_b);
      end else begin
        chk("resp_busy", busy, 1);
        chk("resp_rsp_valid", rsp_valid, 1);
        chk("resp_ready", {req1_ready, req0_ready}, 0);
        chk("resp_id", rsp_id, m_id);
        chk("resp_result", rsp_result, alu_fn(m_op, m_a, m_b));
        if (rsp_ready) begin
          m_busy = 1'b0;
          m_last = m_id;
        end
      end
    end
  end

  task automatic drive(bit v0, bit v1, logic [3:0] c0, logic [3:0] c1,
                       logic [31:0] a0, logic [31:0] b0, logic [31:0] a1, logic [31:0] b1,
                       bit rr);
    @(posedge clk);
    #1;
    req0_valid = v0; req1_valid = v1;
    req0_ctrl  = c0; req1_ctrl  = c1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    rsp_ready = rr;
  endtask

  task automatic idle(int n, bit rr);
    for (int i = 0; i < n; i++) drive(0, 0, 4'd0, 4'd0, $urandom, $urandom, $urandom, $urandom, rr);
  endtask

  logic [3:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_PASS, 4'b0000, 4'b1001};

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_ctrl = 0; req1_ctrl = 0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy_after", busy, 0);

    // ADD 5+7 from req0
    drive(1, 0, OP_ADD, 4'd0, 5, 7, 0, 0, 1);
    idle(5, 1);
    // MULT 6*7 from req1
    drive(0, 1, 4'd0, OP_MUL, 0, 0, 6, 7, 1);
    idle(7, 1);
    // continuous tie: SUB on req0, OR on req1
    repeat (14) drive(1, 1, OP_SUB, OP_OR, 10, 3, 32'hF0, 32'h0F, 1);
    idle(4, 1);
    // consumer stalls in RESP
    drive(1, 0, OP_AND, 4'd0, 32'hFF00, 32'h0FF0, 0, 0, 0);
    idle(8, 0);
    idle(3, 1);
    // reset during the second EXEC cycle of a MULT, then a tie
    drive(1, 0, OP_MUL, 4'd0, 9, 9, 0, 0, 1);
    idle(1, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    req0_valid = 1; req1_valid = 1;
    req0_ctrl = OP_ADD; req1_ctrl = OP_SUB;
    req0_a = 1; req0_b = 2; req1_a = 8; req1_b = 3;
    idle(6, 1);

    // random traffic, including unlisted opcodes and consumer stalls
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            ops[$urandom_range(0, 7)], ops[$urandom_range(0, 7)],
            $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20), $urandom_range(0, 300),
            $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20), $urandom_range(0, 300),
            $urandom_range(0, 3) != 0);
    end
    idle(10, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
